pdp11_mem_sequencer: RTL
========================

// Module: pdp11_mem_sequencer
// PURPOSE
//  Sequences and arbitrates all 16-bit PDP-11 memory traffic onto the 8-bit-wide (MEM_WIDTH) byte memory.
//  Two requesters share the memory: the instruction-fetch unit (word reads) and the operand/data unit
//  (word/byte, read/write). Each word access becomes two byte cycles, little-endian (low byte at A, high at A+1).
//  Emits one trace strobe per transaction, encoded as mem_access_t, for the trace-file writer.
// PARAMETERS
//  ADDR_W   16  address width (MEM_ADDR_LEN)
//  DATA_W   16  requester data width (WORD_SIZE)
//  MEM_W     8  memory data width (MEM_WIDTH)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  if_req       in   1       fetch request (level, held until if_done)
//  if_addr      in   ADDR_W  fetch address (word, must be even)
//  if_done      out  1       1-cycle completion pulse, fetch
//  if_rdata     out  DATA_W  fetched word, valid with if_done, held until next if_done
//  if_err       out  1       odd-address error, valid with if_done
//  d_req        in   1       data request (level, held until d_done)
//  d_we         in   1       1=write (DATA_WRITE), 0=read (DATA_READ)
//  d_byte       in   1       op_size: 0=word_op, 1=byte_op
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  write data; byte_op uses [7:0]
//  d_done       out  1       1-cycle completion pulse, data
//  d_rdata      out  DATA_W  read data; byte_op returns {8'h00,byte}; held until next d_done
//  d_err        out  1       odd word-address error, valid with d_done
//  mem_en       out  1       memory byte access strobe
//  mem_we       out  1       memory write enable (qualified by mem_en)
//  mem_addr     out  ADDR_W  memory byte address
//  mem_wdata    out  MEM_W   memory write byte
//  mem_rdata    in   MEM_W   memory read byte, valid the cycle AFTER mem_en&!mem_we
//  trace_valid  out  1       1-cycle trace strobe
//  trace_type   out  2       0=DATA_READ 1=DATA_WRITE 2=INSTRUCTION_FETCH
//  trace_addr   out  ADDR_W  transaction start address
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0; rdata regs 0; last_gnt=FETCH (data wins first tie).
//  FSM: IDLE -> ACC0 -> [ACC1 if word] -> CAP -> RESP -> IDLE; IDLE -> RESP directly on error.
//  IDLE: sample reqs. One pending -> grant it. Both -> grant the one != last_gnt (round robin).
//   Latch addr/we/size/wdata and requester id; update last_gnt. Inputs are not sampled again.
//   Word access with addr[0]=1 -> err=1, no mem_en, no trace, go RESP.
//  ACC0: mem_en=1, mem_addr=A, mem_we=we, mem_wdata=wdata[7:0]; trace_valid=1 (type, A).
//  ACC1: mem_en=1, mem_addr=A+1 (mod 2^ADDR_W), mem_wdata=wdata[15:8]; read: capture low byte from mem_rdata.
//  CAP: no mem_en; read: capture high byte (word) or low byte (byte, upper forced 0). Write: pass-through.
//  RESP: assert granted port's done (+err) for exactly 1 cycle; update that port's rdata (reads only;
//   writes and errors leave rdata unchanged). Other port's outputs untouched.
//  Latency, req first seen in IDLE at cycle N: word done N+4; byte done N+3; error done N+1.
//  Requester drops req in the cycle after done; req still high in IDLE is a new transaction.
//  Back-to-back: next grant earliest in IDLE cycle N+5 (word). Requests during busy wait, never lost.
//  mem_* outputs decode only from registered state/latched operands (no combinational req->mem path).
//  Byte write touches exactly one address; word write exactly two; memory never sees a write on error.
//  Address 0xFFFF byte access legal; word at 0xFFFE uses 0xFFFE/0xFFFF (no wrap needed).
// TESTING
//  1 Fetch 0x0100, mem[0x100]=34 mem[0x101]=12 -> mem_en at N+1,N+2; if_rdata=0x1234, if_done @N+4, trace type 2 addr 0x0100.
//  2 Data byte write 0x0203 wdata=0xABCD -> single mem write addr 0x0203 data 0xCD; d_done @N+3, trace type 1.
//  3 Data word read 0x0101 -> d_err=1, d_done @N+1, no mem_en, no trace_valid, d_rdata unchanged.
//  4 if_req and d_req held together for 4 transactions -> grant order D,F,D,F; each done exactly once.
//  5 Byte read 0x0007, mem=0xF0 -> d_rdata=0x00F0 @N+3; word write 0x0400=0xBEEF -> mem[400]=EF, mem[401]=BE.
//  6 rst_n low during ACC1 -> all outputs 0 immediately, no done; after release fetch 0x0100 completes per test 1.

Source files
------------

// File: rtl/pdp11_mem_sequencer_if.sv
// Requester, byte-memory and trace signal bundle for the PDP-11 memory sequencer.
// The slave modport is the sequencer side; the master modport is the surrounding system.
interface pdp11_mem_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_W  = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic              d_byte;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  logic              trace_valid;
  logic [1:0]        trace_type;
  logic [ADDR_W-1:0] trace_addr;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, if_err, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata,
           trace_valid, trace_type, trace_addr, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, if_err, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata,
           trace_valid, trace_type, trace_addr, busy
  );
endinterface

// File: rtl/pdp11_mem_sequencer.sv
// Arbitrates instruction-fetch and data requests onto an 8-bit byte memory,
// splitting words into two little-endian byte cycles and emitting one trace strobe per access.
module pdp11_mem_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int MEM_W  = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pdp11_mem_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_CAP,
    S_RESP
  } state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } gnt_t;

  state_t            state, state_n;
  gnt_t              last_gnt, gnt, sel_gnt;
  logic [ADDR_W-1:0] l_addr, sel_addr;
  logic              l_we, l_byte, l_err;
  logic [DATA_W-1:0] l_wdata;
  logic [MEM_W-1:0]  lo_byte;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q, rd_word;
  logic              take, sel_err;

  // Next state and grant decision; requester inputs are only looked at in IDLE.
  always_comb begin
    state_n  = state;
    take     = 1'b0;
    sel_gnt  = GNT_FETCH;
    sel_addr = bus.if_addr;
    sel_err  = 1'b0;
    rd_word  = l_byte ? DATA_W'(bus.mem_rdata) : {bus.mem_rdata, lo_byte};
    unique case (state)
      S_IDLE: begin
        // On a tie, grant whichever requester was not served last.
        if (bus.d_req && (!bus.if_req || last_gnt == GNT_FETCH)) begin
          take     = 1'b1;
          sel_gnt  = GNT_DATA;
          sel_addr = bus.d_addr;
          sel_err  = !bus.d_byte && bus.d_addr[0];
        end else if (bus.if_req) begin
          take     = 1'b1;
          sel_gnt  = GNT_FETCH;
          sel_addr = bus.if_addr;
          sel_err  = bus.if_addr[0];
        end
        if (take) state_n = sel_err ? S_RESP : S_ACC0;
      end
      S_ACC0:  state_n = l_byte ? S_CAP : S_ACC1;
      S_ACC1:  state_n = S_CAP;
      S_CAP:   state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_gnt   <= GNT_FETCH;
      gnt        <= GNT_FETCH;
      l_addr     <= '0;
      l_we       <= 1'b0;
      l_byte     <= 1'b0;
      l_err      <= 1'b0;
      l_wdata    <= '0;
      lo_byte    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        gnt      <= sel_gnt;
        last_gnt <= sel_gnt;
        l_addr   <= sel_addr;
        l_we     <= (sel_gnt == GNT_DATA) && bus.d_we;
        l_byte   <= (sel_gnt == GNT_DATA) && bus.d_byte;
        l_wdata  <= (sel_gnt == GNT_DATA) ? bus.d_wdata : '0;
        l_err    <= sel_err;
      end
      if (state == S_ACC1 && !l_we) lo_byte <= bus.mem_rdata;
      // Read data lands in the port register on entry to RESP so it is valid with done.
      if (state == S_CAP && !l_we) begin
        if (gnt == GNT_FETCH) if_rdata_q <= rd_word;
        else                  d_rdata_q  <= rd_word;
      end
    end
  end

  // Outputs decode purely from registered state and latched operands.
  always_comb begin
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.trace_valid = 1'b0;
    bus.trace_type  = 2'd0;
    bus.trace_addr  = '0;
    bus.if_done     = 1'b0;
    bus.if_err      = 1'b0;
    bus.d_done      = 1'b0;
    bus.d_err       = 1'b0;
    bus.busy        = (state != S_IDLE);
    bus.if_rdata    = if_rdata_q;
    bus.d_rdata     = d_rdata_q;
    unique case (state)
      S_ACC0: begin
        bus.mem_en      = 1'b1;
        bus.mem_we      = l_we;
        bus.mem_addr    = l_addr;
        bus.mem_wdata   = l_wdata[MEM_W-1:0];
        bus.trace_valid = 1'b1;
        bus.trace_type  = (gnt == GNT_FETCH) ? 2'd2 : {1'b0, l_we};
        bus.trace_addr  = l_addr;
      end
      S_ACC1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = l_we;
        bus.mem_addr  = l_addr + ADDR_W'(1);
        bus.mem_wdata = l_wdata[DATA_W-1:MEM_W];
      end
      S_RESP: begin
        if (gnt == GNT_FETCH) begin
          bus.if_done = 1'b1;
          bus.if_err  = l_err;
        end else begin
          bus.d_done = 1'b1;
          bus.d_err  = l_err;
        end
      end
      default: ;
    endcase
  end

endmodule
